pipe_add_sub: RTL and testbench

PIPE_ADD_SUB -- requirements
Module: pipe_add_sub

---
 rtl/add_sub_pkg.sv | 12 +
 rtl/add_sub_slice.sv | 17 +
 rtl/pipe_add_sub.sv | 103 ++++++++++
 tb/tb_pipe_add_sub.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// Shared constants and operation encoding for the pipelined adder/subtractor.
package add_sub_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/add_sub_slice.sv
// Combinational CW-bit chunk adder; also exposes the carry into its top bit
// so the final chunk can derive signed overflow.
module add_sub_slice #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          ci,
  output logic [CW-1:0] s,
  output logic          co,
  output logic          cm
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, ci};
  assign cm      = a[CW-1] ^ b[CW-1] ^ s[CW-1];

endmodule

// File: rtl/pipe_add_sub.sv
// Carry-pipelined WIDTH-bit add/subtract: one CW-bit chunk resolved per stage,
// operands skewed through the stage registers, whole-pipe stall on backpressure.
module pipe_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = WIDTH / STAGES;

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf;
    logic             z;
  } stage_t;

  op_e    op;
  logic   stall;
  stage_t head;
  stage_t st_q [STAGES];
  stage_t nxt  [STAGES];

  assign op       = op_e'(sub);
  assign stall    = st_q[STAGES-1].v & ~out_ready;
  assign in_ready = ~rst & ~stall;

  // Subtraction is A + ~B + 1; cin acts as borrow-in, hence the XOR.
  always_comb begin
    head   = '0;
    head.v = in_valid;
    head.a = a;
    head.b = (op == OP_SUB) ? ~b : b;
    head.c = (op == OP_SUB) ^ cin;
  end

  for (genvar k = 0; k < STAGES; k++) begin : gen_stage
    stage_t          src;
    stage_t          upd;
    logic [CW-1:0]   s_k;
    logic            co_k;
    logic            cm_k;

    if (k == 0) begin : g_head
      assign src = head;
    end else begin : g_tail
      assign src = st_q[k-1];
    end

    add_sub_slice #(.CW(CW)) u_slice (
      .a  (src.a[k*CW +: CW]),
      .b  (src.b[k*CW +: CW]),
      .ci (src.c),
      .s  (s_k),
      .co (co_k),
      .cm (cm_k)
    );

    always_comb begin
      upd                = src;
      upd.s[k*CW +: CW]  = s_k;
      upd.c              = co_k;
      upd.ovf            = cm_k ^ co_k;
      upd.z              = (upd.s == '0);
    end

    assign nxt[k] = upd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) st_q[k] <= '0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) st_q[k] <= nxt[k];
    end
  end

  assign out_valid = st_q[STAGES-1].v;
  assign sum       = st_q[STAGES-1].s;
  assign cout      = st_q[STAGES-1].c;
  assign ovf       = st_q[STAGES-1].ovf;
  assign zero      = st_q[STAGES-1].z;

endmodule

// File: tb/tb_pipe_add_sub.sv
// Randomized scoreboard bench for pipe_add_sub against an arithmetic reference model.
module tb_pipe_add_sub;

  localparam int W = 32;
  localparam int S = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf, zero;
  logic [W-1:0]  a, b, sum;

  logic          v64, sub64, cin64, or64;
  logic [63:0]   a64, b64;
  logic          ir1, ov1, c1, o1, z1, ir8, ov8, c8, o8, z8;
  logic [63:0]   s1, s8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           cyc;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];
  int   cyc;
  int   n_checks;
  int   n_fail;

  always #5 clk = ~clk;

  pipe_add_sub #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf), .zero(zero)
  );

  pipe_add_sub #(.WIDTH(64), .STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(ir1), .a(a64), .b(b64),
    .sub(sub64), .cin(cin64), .out_valid(ov1), .out_ready(or64), .sum(s1),
    .cout(c1), .ovf(o1), .zero(z1)
  );

  pipe_add_sub #(.WIDTH(64), .STAGES(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(ir8), .a(a64), .b(b64),
    .sub(sub64), .cin(cin64), .out_valid(ov8), .out_ready(or64), .sum(s8),
    .cout(c8), .ovf(o8), .zero(z8)
  );

  // Reference: exact integer arithmetic in 34 bits, signed range test for overflow.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic op_sub, input logic ci);
    res_t        r;
    logic [33:0] u;
    logic [33:0] sg;
    logic [33:0] xs;
    logic [33:0] ys;
    xs = {{2{x[W-1]}}, x};
    ys = {{2{y[W-1]}}, y};
    if (!op_sub) begin
      u      = {2'b00, x} + {2'b00, y} + {33'd0, ci};
      sg     = xs + ys + {33'd0, ci};
      r.cout = u[32];
    end else begin
      u      = {2'b00, x} - {2'b00, y} - {33'd0, ci};
      sg     = xs - ys - {33'd0, ci};
      r.cout = ~u[33];
    end
    r.sum  = u[W-1:0];
    r.ovf  = !((sg[33:31] == 3'b000) || (sg[33:31] == 3'b111));
    r.zero = (r.sum == '0);
    r.cyc  = 0;
    return r;
  endfunction

  task automatic rand_beat();
    a   = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFF : $urandom;
    b   = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
    sub = 1'($urandom_range(0, 1));
    cin = 1'($urandom_range(0, 1));
  endtask

  // One clock: record transfers on both interfaces just before the edge.
  task automatic tick();
    res_t r;
    #1;
    if (out_valid && out_ready) begin
      r.sum = sum; r.cout = cout; r.ovf = ovf; r.zero = zero; r.cyc = cyc;
      obs_q.push_back(r);
    end
    if (in_valid && in_ready) begin
      r     = model(a, b, sub, cin);
      r.cyc = cyc;
      exp_q.push_back(r);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    v64 = 1'b0; a64 = '0; b64 = '0; sub64 = 1'b0; cin64 = 1'b0; or64 = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if ({sum, cout, ovf, zero} !== '0)
      begin n_fail++; $display("[TB] FAIL reset_outputs: got sum=%h c=%b o=%b z=%b want all 0", sum, cout, ovf, zero); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL idle_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [W-1:0] da [2];
    logic [W-1:0] db [2];
    logic         ds [2];
    logic [W-1:0] es [2];
    logic [2:0]   ef [2];
    int           lat;
    da[0] = 32'hFFFF_FFFF; db[0] = 32'h0000_0001; ds[0] = 1'b0; es[0] = 32'h0;         ef[0] = 3'b101;
    da[1] = 32'h8000_0000; db[1] = 32'h0000_0001; ds[1] = 1'b1; es[1] = 32'h7FFF_FFFF; ef[1] = 3'b110;
    for (int i = 0; i < 2; i++) begin
      exp_q.delete(); obs_q.delete();
      out_ready = 1'b1; in_valid = 1'b1; a = da[i]; b = db[i]; sub = ds[i]; cin = 1'b0;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin tick(); lat++; end
      n_checks++;
      if (lat != S) begin n_fail++; $display("[TB] FAIL directed%0d_latency: got %0d want %0d", i, lat, S); end
      n_checks++;
      if ({sum, cout, ovf, zero} !== {es[i], ef[i]})
        begin n_fail++; $display("[TB] FAIL directed%0d_result: got %h %b%b%b want %h %b", i, sum, cout, ovf, zero, es[i], ef[i]); end
      tick();
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int n;
    exp_q.delete(); obs_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin in_valid = 1'b1; rand_beat(); tick(); end
    in_valid = 1'b0;
    for (int t = 0; t < 40 && obs_q.size() < 16; t++) tick();
    n_checks++;
    if (obs_q.size() != 16 || exp_q.size() != 16)
      begin n_fail++; $display("[TB] FAIL b2b_count: got %0d results for %0d beats want 16", obs_q.size(), exp_q.size()); end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    if (n > 0) begin
      n_checks++;
      if (obs_q[0].cyc - exp_q[0].cyc != S)
        begin n_fail++; $display("[TB] FAIL b2b_latency: got %0d want %0d", obs_q[0].cyc - exp_q[0].cyc, S); end
    end
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (obs_q[i].sum !== exp_q[i].sum || obs_q[i].cout !== exp_q[i].cout || obs_q[i].ovf !== exp_q[i].ovf ||
          obs_q[i].zero !== exp_q[i].zero || obs_q[i].cyc != obs_q[0].cyc + i)
        begin n_fail++; $display("[TB] FAIL b2b_beat%0d: got %h %b%b%b @%0d want %h %b%b%b @%0d", i, obs_q[i].sum,
               obs_q[i].cout, obs_q[i].ovf, obs_q[i].zero, obs_q[i].cyc, exp_q[i].sum, exp_q[i].cout,
               exp_q[i].ovf, exp_q[i].zero, obs_q[0].cyc + i); end
    end
  endtask

  task automatic test_stall();
    int n;
    exp_q.delete(); obs_q.delete();
    out_ready = 1'b0;
    for (int t = 0; t < 6; t++) begin in_valid = 1'b1; rand_beat(); tick(); end
    n_checks++;
    if (exp_q.size() != S) begin n_fail++; $display("[TB] FAIL stall_fill: got %0d accepted want %0d", exp_q.size(), S); end
    for (int t = 0; t < 6; t++) begin
      in_valid = 1'b1; rand_beat(); tick();
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || exp_q.size() == 0 ||
          {sum, cout, ovf, zero} !== {exp_q[0].sum, exp_q[0].cout, exp_q[0].ovf, exp_q[0].zero})
        begin n_fail++; $display("[TB] FAIL stall_hold%0d: got rdy=%b vld=%b sum=%h want rdy=0 vld=1 sum=%h", t, in_ready,
               out_valid, sum, (exp_q.size() > 0) ? exp_q[0].sum : 32'h0); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 30 && obs_q.size() < exp_q.size(); t++) tick();
    n_checks++;
    if (obs_q.size() != exp_q.size())
      begin n_fail++; $display("[TB] FAIL stall_drain_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if ({obs_q[i].sum, obs_q[i].cout, obs_q[i].ovf, obs_q[i].zero} !==
          {exp_q[i].sum, exp_q[i].cout, exp_q[i].ovf, exp_q[i].zero})
        begin n_fail++; $display("[TB] FAIL stall_drain%0d: got %h want %h", i, obs_q[i].sum, exp_q[i].sum); end
    end
  endtask

  task automatic test_random_flow();
    int n;
    exp_q.delete(); obs_q.delete();
    for (int t = 0; t < 300; t++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_beat();
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 50 && obs_q.size() < exp_q.size(); t++) tick();
    n_checks++;
    if (obs_q.size() != exp_q.size())
      begin n_fail++; $display("[TB] FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if ({obs_q[i].sum, obs_q[i].cout, obs_q[i].ovf, obs_q[i].zero} !==
          {exp_q[i].sum, exp_q[i].cout, exp_q[i].ovf, exp_q[i].zero})
        begin n_fail++; $display("[TB] FAIL random_beat%0d: got %h %b%b%b want %h %b%b%b", i, obs_q[i].sum, obs_q[i].cout,
               obs_q[i].ovf, obs_q[i].zero, exp_q[i].sum, exp_q[i].cout, exp_q[i].ovf, exp_q[i].zero); end
    end
  endtask

  task automatic test_reset_midflight();
    int   lat;
    res_t r;
    exp_q.delete(); obs_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin in_valid = 1'b1; rand_beat(); tick(); end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL midflight_pre: got %b want 1", out_valid); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || {sum, cout, ovf, zero} !== '0)
      begin n_fail++; $display("[TB] FAIL midflight_async: got vld=%b rdy=%b sum=%h z=%b want all 0", out_valid, in_ready, sum, zero); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete(); obs_q.delete();
    for (int t = 0; t < 10; t++) tick();
    n_checks++;
    if (obs_q.size() != 0) begin n_fail++; $display("[TB] FAIL midflight_stale: got %0d beats want 0", obs_q.size()); end
    in_valid = 1'b1; rand_beat();
    r = model(a, b, sub, cin);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    n_checks++;
    if (lat != S || {sum, cout, ovf, zero} !== {r.sum, r.cout, r.ovf, r.zero})
      begin n_fail++; $display("[TB] FAIL midflight_after: got lat=%0d sum=%h want lat=%0d sum=%h", lat, sum, S, r.sum); end
    tick();
  endtask

  task automatic test_wide();
    int lat1;
    int lat8;
    logic [63:0] g1;
    logic [63:0] g8;
    logic [2:0]  f1;
    logic [2:0]  f8;
    lat1 = 0; lat8 = 0; g1 = '0; g8 = '0; f1 = '0; f8 = '0;
    a64 = 64'h7FFF_FFFF_FFFF_FFFF; b64 = 64'h1; sub64 = 1'b0; cin64 = 1'b0; v64 = 1'b1;
    #1;
    n_checks++;
    if (ir1 !== 1'b1 || ir8 !== 1'b1) begin n_fail++; $display("[TB] FAIL wide_ready: got %b%b want 11", ir1, ir8); end
    for (int n = 1; n <= 20 && (lat1 == 0 || lat8 == 0); n++) begin
      @(posedge clk);
      #1;
      v64 = 1'b0;
      if (ov1 && lat1 == 0) begin lat1 = n; g1 = s1; f1 = {c1, o1, z1}; end
      if (ov8 && lat8 == 0) begin lat8 = n; g8 = s8; f8 = {c8, o8, z8}; end
    end
    n_checks++;
    if (lat1 != 1 || g1 !== 64'h8000_0000_0000_0000 || f1 !== 3'b010)
      begin n_fail++; $display("[TB] FAIL wide_s1: got lat=%0d sum=%h f=%b want lat=1 sum=8000000000000000 f=010", lat1, g1, f1); end
    n_checks++;
    if (lat8 != 8 || g8 !== 64'h8000_0000_0000_0000 || f8 !== 3'b010)
      begin n_fail++; $display("[TB] FAIL wide_s8: got lat=%0d sum=%h f=%b want lat=8 sum=8000000000000000 f=010", lat8, g8, f8); end
  endtask

  initial begin
    cyc = 0; n_checks = 0; n_fail = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_random_flow();
    test_reset_midflight();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
